// File: rtl/conv_mac_engine_if.sv
// Bundle of kernel-load, pixel-stream and result-stream signals for conv_mac_engine.
// Names carry the engine's direction: i_* flow into the engine and o_* flow out of it.
interface conv_mac_if #(
    parameter int KERNEL_SIZE = 3,
    parameter int DATA_WIDTH  = 8,
    parameter int CHANNELS    = 2
);
    localparam int N          = CHANNELS * KERNEL_SIZE * KERNEL_SIZE;
    localparam int ADDR_WIDTH = $clog2(N);

    // Handshake rule for both streams:
    //  - A beat transfers on a rising edge where valid and ready are both 1.
    //  - Once valid is raised, the sender holds its data stable until that edge.
    //  - Ready may change freely and never depends on the same cycle's valid.
    logic                         i_kernel_wr;
    logic [ADDR_WIDTH-1:0]        i_kernel_addr;
    logic signed [DATA_WIDTH-1:0] i_kernel_data;
    logic                         i_start;
    logic [4:0]                   i_shift;
    logic                         i_relu_en;
    logic                         i_pix_valid;
    logic signed [DATA_WIDTH-1:0] i_pix_data;
    logic                         o_pix_ready;
    logic signed [DATA_WIDTH-1:0] o_result;
    logic                         o_valid;
    logic                         i_result_ready;
    logic                         o_busy;
    logic                         o_done;

    modport slave (
        input  i_kernel_wr, i_kernel_addr, i_kernel_data,
        input  i_start, i_shift, i_relu_en,
        input  i_pix_valid, i_pix_data, i_result_ready,
        output o_pix_ready, o_result, o_valid, o_busy, o_done
    );

    modport master (
        output i_kernel_wr, i_kernel_addr, i_kernel_data,
        output i_start, i_shift, i_relu_en,
        output i_pix_valid, i_pix_data, i_result_ready,
        input  o_pix_ready, o_result, o_valid, o_busy, o_done
    );
endinterface

// File: rtl/conv_mac_engine.sv
// Multi-channel convolution MAC: one streamed window against a stored kernel,
// producing a single shifted, optionally ReLU'd, saturated output pixel.
module conv_mac_engine #(
    parameter int KERNEL_SIZE = 3,
    parameter int DATA_WIDTH  = 8,
    parameter int CHANNELS    = 2,
    parameter int ACC_WIDTH   = 24
) (
    input  logic       i_clk,
    input  logic       i_rst,
    conv_mac_if.slave  bus,
    output logic [2:0] o_state
);
    localparam int N          = CHANNELS * KERNEL_SIZE * KERNEL_SIZE;
    localparam int ADDR_WIDTH = $clog2(N);
    localparam int PROD_WIDTH = 2 * DATA_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(N - 1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ACCUM = 3'd1,
        S_DRAIN = 3'd2,
        S_POST  = 3'd3,
        S_OUT   = 3'd4
    } state_t;

    state_t                       r_state;
    state_t                       w_next_state;
    logic signed [DATA_WIDTH-1:0] r_kernel [N];
    logic signed [ACC_WIDTH-1:0]  r_acc;
    logic signed [PROD_WIDTH-1:0] r_prod;
    logic                         r_prod_vld;
    logic [ADDR_WIDTH-1:0]        r_idx;
    logic [4:0]                   r_shift;
    logic                         r_relu;
    logic signed [DATA_WIDTH-1:0] r_result;
    logic                         r_valid;
    logic                         r_done;

    logic                         w_pix_ready;
    logic                         w_busy;
    logic                         w_accept;
    logic                         w_out_hs;
    logic                         w_start;
    logic                         w_kernel_we;
    logic signed [PROD_WIDTH-1:0] w_prod;
    logic signed [ACC_WIDTH-1:0]  w_prod_ext;
    logic signed [ACC_WIDTH-1:0]  w_shifted;
    logic signed [ACC_WIDTH-1:0]  w_relu_val;
    logic signed [DATA_WIDTH-1:0] w_requant;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_pix_ready  = 1'b0;
        w_busy       = 1'b1;
        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (bus.i_start) begin
                    w_next_state = S_ACCUM;
                end
            end
            S_ACCUM: begin
                w_pix_ready = 1'b1;
                if (bus.i_pix_valid && (r_idx == LAST_IDX)) begin
                    w_next_state = S_DRAIN;
                end
            end
            S_DRAIN: w_next_state = S_POST;
            S_POST:  w_next_state = S_OUT;
            S_OUT: begin
                if (bus.i_result_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    assign w_accept    = bus.i_pix_valid & w_pix_ready;
    assign w_out_hs    = (r_state == S_OUT) & bus.i_result_ready;
    assign w_start     = (r_state == S_IDLE) & bus.i_start;
    assign w_kernel_we = (r_state == S_IDLE) & bus.i_kernel_wr & (bus.i_kernel_addr <= LAST_IDX);
    assign w_prod      = PROD_WIDTH'(bus.i_pix_data) * PROD_WIDTH'(r_kernel[r_idx]);
    assign w_prod_ext  = ACC_WIDTH'(r_prod);

    // Requantise: floor shift, clamp negatives if ReLU, then saturate to the output range.
    always_comb begin
        w_shifted  = r_acc >>> r_shift;
        w_relu_val = w_shifted;
        if (r_relu && (w_shifted < 0)) begin
            w_relu_val = {ACC_WIDTH{1'b0}};
        end
        if (w_relu_val > SAT_MAX) begin
            w_requant = SAT_MAX[DATA_WIDTH-1:0];
        end else if (w_relu_val < SAT_MIN) begin
            w_requant = SAT_MIN[DATA_WIDTH-1:0];
        end else begin
            w_requant = w_relu_val[DATA_WIDTH-1:0];
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            for (int i = 0; i < N; i++) begin
                r_kernel[i] <= '0;
            end
            r_acc      <= '0;
            r_prod     <= '0;
            r_prod_vld <= 1'b0;
            r_idx      <= '0;
            r_shift    <= '0;
            r_relu     <= 1'b0;
            r_result   <= '0;
            r_valid    <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            if (w_kernel_we) begin
                r_kernel[bus.i_kernel_addr] <= bus.i_kernel_data;
            end
            // The product is registered one cycle ahead of the add, so the flag marks a fresh one.
            r_prod_vld <= w_accept;
            if (w_accept) begin
                r_prod <= w_prod;
                r_idx  <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
            end
            if (w_start) begin
                r_shift    <= bus.i_shift;
                r_relu     <= bus.i_relu_en;
                r_acc      <= '0;
                r_idx      <= '0;
                r_prod_vld <= 1'b0;
            end else if (r_prod_vld) begin
                r_acc <= r_acc + w_prod_ext;
            end
            if (r_state == S_POST) begin
                r_result <= w_requant;
                r_valid  <= 1'b1;
            end
            if (w_out_hs) begin
                r_valid <= 1'b0;
            end
            r_done <= w_out_hs;
        end
    end

    assign bus.o_pix_ready = w_pix_ready;
    assign bus.o_busy      = w_busy;
    assign bus.o_result    = r_result;
    assign bus.o_valid     = r_valid;
    assign bus.o_done      = r_done;
    assign o_state         = r_state;
endmodule

// File: tb/tb_conv_mac_engine.sv
// Bench for conv_mac_engine: directed corner windows plus randomized windows
// with bubbles, result stalls and ignored mid-operation writes/starts.
`timescale 1ns/1ps
module tb_conv_mac_engine;
    localparam int K  = 3;
    localparam int DW = 8;
    localparam int CH = 2;
    localparam int AW = 24;
    localparam int N  = CH * K * K;
    localparam int ADDR_W = $clog2(N);

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] dut_state;
    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc = 0;

    conv_mac_if #(.KERNEL_SIZE(K), .DATA_WIDTH(DW), .CHANNELS(CH)) bus();

    conv_mac_engine #(
        .KERNEL_SIZE(K), .DATA_WIDTH(DW), .CHANNELS(CH), .ACC_WIDTH(AW)
    ) dut (
        .i_clk   (clk),
        .i_rst   (rst_n),
        .bus     (bus),
        .o_state (dut_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- model ----------------
    int     kern_m [N];
    int     pix_m  [N];
    longint model_sum;
    logic [DW-1:0] exp_q [$];

    function automatic int model_result(int sh, bit relu);
        longint s = 0;
        longint t;
        for (int i = 0; i < N; i++) s += longint'(kern_m[i]) * longint'(pix_m[i]);
        model_sum = s;
        t = s >>> sh;
        if (relu && t < 0) t = 0;
        if (t > 127) t = 127;
        if (t < -128) t = -128;
        return int'(t);
    endfunction

    task automatic check(string name, longint act, longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- scoreboard / compare ----------------
    logic prev_hs = 1'b0;
    logic prev_valid = 1'b0;
    int   rise_cyc = 0;
    logic signed [DW-1:0] last_result = '0;

    always @(negedge clk) begin
        if (rst_n) begin
            check("done_pulse", bus.o_done, prev_hs);
            if (bus.o_valid) begin
                if (exp_q.size() == 0) check("unexpected_valid", 1, 0);
                else check("result", $signed(bus.o_result), $signed(exp_q[0]));
                if (!prev_valid) rise_cyc = cyc;
                if (bus.i_result_ready) begin
                    last_result = bus.o_result;
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                end
            end
            prev_hs = bus.o_valid && bus.i_result_ready;
        end else begin
            prev_hs = 1'b0;
        end
        prev_valid = bus.o_valid;
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_kernel(int addr, int data);
        bus.i_kernel_wr   = 1'b1;
        bus.i_kernel_addr = ADDR_W'(addr);
        bus.i_kernel_data = DW'(data);
        tick();
        bus.i_kernel_wr = 1'b0;
        kern_m[addr] = data;
    endtask

    task automatic fill_kernel(int v);
        for (int i = 0; i < N; i++) write_kernel(i, v);
    endtask

    task automatic fill_pix(int v);
        for (int i = 0; i < N; i++) pix_m[i] = v;
    endtask

    int start_cyc = 0;

    task automatic run_op(int sh, bit relu, int bubble_pct, int stall, bit junk, output int exp_val);
        int wc;
        exp_val = model_result(sh, relu);
        exp_q.push_back(exp_val[DW-1:0]);
        bus.i_start   = 1'b1;
        bus.i_shift   = 5'(sh);
        bus.i_relu_en = relu;
        tick();
        start_cyc = cyc;
        bus.i_start = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (int'($urandom_range(99)) < bubble_pct) begin
                bus.i_pix_valid = 1'b0;
                repeat ($urandom_range(1, 2)) tick();
            end
            bus.i_pix_valid = 1'b1;
            bus.i_pix_data  = DW'(pix_m[i]);
            if (junk && i == 3) begin
                bus.i_start       = 1'b1;
                bus.i_shift       = 5'd0;
                bus.i_relu_en     = ~relu;
                bus.i_kernel_wr   = 1'b1;
                bus.i_kernel_addr = ADDR_W'(i);
                bus.i_kernel_data = DW'($urandom);
            end
            wc = 0;
            while (!bus.o_pix_ready && wc < 50) begin
                tick();
                wc++;
            end
            if (!bus.o_pix_ready) begin
                check("pix_ready_timeout", 0, 1);
                break;
            end
            tick();
            bus.i_start     = 1'b0;
            bus.i_kernel_wr = 1'b0;
        end
        bus.i_pix_valid = 1'b0;
        if (stall > 0) begin
            bus.i_result_ready = 1'b0;
            wc = 0;
            while (!bus.o_valid && wc < 50) begin
                tick();
                wc++;
            end
            repeat (stall) tick();
            bus.i_result_ready = 1'b1;
        end
        wc = 0;
        while (!bus.o_done && wc < 60) begin
            tick();
            wc++;
        end
        if (!bus.o_done) check("done_timeout", 0, 1);
    endtask

    // ---------------- stimulus ----------------
    int ev;

    initial begin
        bus.i_kernel_wr = 0; bus.i_kernel_addr = '0; bus.i_kernel_data = '0;
        bus.i_start = 0; bus.i_shift = '0; bus.i_relu_en = 0;
        bus.i_pix_valid = 0; bus.i_pix_data = '0; bus.i_result_ready = 0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_state", dut_state, 0);
        check("rst_busy", bus.o_busy, 0);
        check("rst_valid", bus.o_valid, 0);
        check("rst_done", bus.o_done, 0);
        check("rst_pix_ready", bus.o_pix_ready, 0);
        check("rst_result", $signed(bus.o_result), 0);
        tick();
        bus.i_result_ready = 1'b1;

        // all ones
        fill_kernel(1); fill_pix(1);
        run_op(0, 0, 0, 0, 0, ev);
        check("model_ones", ev, 18);
        check("dut_ones", last_result, 18);
        check("latency_ones", rise_cyc - start_cyc, 20);

        // positive saturation and large shift
        fill_kernel(127); fill_pix(127);
        run_op(0, 0, 0, 0, 0, ev);
        check("model_sum_pos", model_sum, 290322);
        check("dut_sat_pos", last_result, 127);
        run_op(15, 0, 0, 0, 0, ev);
        check("model_shift15", ev, 8);
        check("dut_shift15", last_result, 8);

        // negative values, ReLU, floor shift
        fill_kernel(-1); fill_pix(5);
        run_op(0, 0, 0, 0, 0, ev);
        check("dut_neg", last_result, -90);
        run_op(0, 1, 0, 0, 0, ev);
        check("dut_relu", last_result, 0);
        run_op(2, 0, 0, 0, 0, ev);
        check("model_floor", ev, -23);
        check("dut_floor", last_result, -23);

        // negative saturation
        fill_kernel(-128); fill_pix(127);
        run_op(0, 0, 0, 0, 0, ev);
        check("model_sum_neg", model_sum, -292608);
        check("dut_sat_neg", last_result, -128);

        // randomized windows with bubbles, stalls and ignored writes/starts
        for (int op = 0; op < 12; op++) begin
            for (int i = 0; i < N; i++) begin
                write_kernel(i, int'($urandom_range(0, 255)) - 128);
                pix_m[i] = int'($urandom_range(0, 255)) - 128;
            end
            run_op(int'($urandom_range(0, 12)), 1'($urandom_range(0, 1)), 30, 5, op[0], ev);
        end

        // reset in the middle of accumulation
        fill_kernel(3); fill_pix(4);
        bus.i_start = 1'b1; bus.i_shift = '0; bus.i_relu_en = 1'b0;
        tick();
        bus.i_start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            bus.i_pix_valid = 1'b1;
            bus.i_pix_data  = DW'(pix_m[i]);
            tick();
        end
        rst_n = 1'b0;
        bus.i_pix_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) kern_m[i] = 0;
        @(negedge clk);
        check("mid_rst_state", dut_state, 0);
        check("mid_rst_busy", bus.o_busy, 0);
        check("mid_rst_valid", bus.o_valid, 0);
        check("mid_rst_done", bus.o_done, 0);
        check("mid_rst_pix_ready", bus.o_pix_ready, 0);
        check("mid_rst_result", $signed(bus.o_result), 0);
        tick();
        for (int i = 0; i < N; i++) pix_m[i] = int'($urandom_range(1, 127));
        run_op(0, 0, 0, 0, 0, ev);
        check("model_zero_kernel", ev, 0);
        check("dut_zero_kernel", last_result, 0);

        // consecutive operations with a kernel change in between
        fill_kernel(2); fill_pix(3);
        run_op(0, 0, 0, 0, 0, ev);
        check("dut_consec_a", last_result, 108);
        fill_kernel(-3); fill_pix(2);
        run_op(0, 0, 0, 0, 0, ev);
        check("dut_consec_b", last_result, -108);

        repeat (3) tick();
        check("exp_q_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/conv_mac_engine.md
# conv_mac_engine

Parametrised multi-channel convolution MAC engine for the NPU datapath. It holds a signed CHANNELS×KERNEL_SIZE×KERNEL_SIZE kernel in an internal register file and consumes one window per operation as a valid/ready pixel stream. It produces one requantised output pixel per window, with right-shift, optional ReLU and saturation. It sits between the window-fetch/SRAM logic and the output writeback buffer.

## Interface
- KERNEL_SIZE, 3, kernel edge length K
- DATA_WIDTH, 8, signed pixel/kernel/result width
- CHANNELS, 2, input channels accumulated into one result
- ACC_WIDTH, 24, signed accumulator width; must be ≥ 2·DATA_WIDTH + clog2(CHANNELS·K·K)
- i_clk  in  1  clock; all logic on rising edge
- i_rst  in  1  reset, synchronous, active-low
- i_kernel_wr  in  1  kernel write strobe
- i_kernel_addr  in  clog2(CHANNELS·K·K)  kernel index, channel-major then row-major
- i_kernel_data  in  DATA_WIDTH  signed kernel value
- i_start  in  1  begin one window operation
- i_shift  in  5  arithmetic right-shift amount, latched at start
- i_relu_en  in  1  ReLU enable, latched at start
- i_pix_valid  in  1  pixel stream valid
- i_pix_data  in  DATA_WIDTH  signed pixel, same ordering as the kernel
- o_pix_ready  out  1  engine accepts a pixel
- o_result  out  DATA_WIDTH  signed requantised result
- o_valid  out  1  o_result valid
- i_result_ready  in  1  downstream accepts o_result
- o_busy  out  1  state ≠ IDLE
- o_done  out  1  one-cycle pulse when the result handshake completes

## Operation
- N = CHANNELS·K·K. States: IDLE, ACCUM, DRAIN, POST, OUT.
- IDLE:
  - A write with i_kernel_wr=1 stores i_kernel_data at i_kernel_addr. Kernel writes outside IDLE are ignored.
  - When i_start=1: latch i_shift and i_relu_en, clear the accumulator, clear the pixel index, go to ACCUM.
- ACCUM:
  - o_pix_ready=1. A pixel is accepted on each edge with i_pix_valid & o_pix_ready.
  - An accepted pixel updates the product register with pix×kernel[index] (full signed 2·DATA_WIDTH), sets the product-valid flag and increments the index.
  - The accumulator adds the sign-extended product on each edge where the product-valid flag is set.
  - Acceptance at index N−1 moves the state to DRAIN.
- DRAIN: one cycle; the final product is added. Go to POST.
- POST: one cycle. t = acc >>> shift (arithmetic, floor toward −∞). If ReLU is enabled and t<0, t=0. Saturate t to [−2^(DW−1), 2^(DW−1)−1], register the value into o_result, set o_valid, go to OUT.
- OUT:
  - o_result and o_valid are held stable until i_result_ready=1.
  - On that edge: o_valid←0, o_done←1 for one cycle, go to IDLE.
- i_start outside IDLE is ignored. o_pix_ready=0 in every state except ACCUM.
- Accumulator never overflows given the ACC_WIDTH rule; no wrap handling.
- Reset (i_rst=0 at an edge), from any state:
  - State←IDLE; accumulator, product and index cleared.
  - Every kernel entry cleared to 0.
  - Outputs: o_result=0, o_valid=0, o_done=0, o_busy=0, o_pix_ready=0.

## Timing
- i_start sampled at edge T → ACCUM after T, so o_pix_ready=1 from T+1.
- Stall-free stream: pixels are accepted at edges T+1…T+N.
  - DRAIN after T+N, POST after T+N+1.
  - o_valid=1 after edge T+N+2. Latency from last accept is 2 edges.
- Bubbles (i_pix_valid=0) extend ACCUM one cycle each and do not otherwise alter the result.
- With i_result_ready held high, o_valid is high exactly one cycle and o_done pulses the cycle after it.
- Back-to-back operation: the earliest next i_start is sampled the cycle after o_done's edge, i.e. while in IDLE.
- A kernel write and i_start on the same IDLE edge: the write takes effect and the operation uses the new value.

## Test plan
- All 18 kernel entries = 1, 18 pixels = 1, shift 0, ReLU off, ready high → o_result=18. o_valid rises 20 edges after start; o_done is a single cycle.
- Kernel 127, pixels 127, shift 0 → acc 290322, o_result=127 (saturated). Same input with shift 15 → o_result=8.
- Kernel −1, pixels 5 (acc −90): ReLU off, shift 0 → −90. ReLU on → 0. ReLU off, shift 2 → −23.
- Kernel −128, pixels 127 → acc −292608, o_result=−128. Then random kernels/pixels with random valid bubbles and i_result_ready held low 5 cycles: result must match a reference model and stay stable while stalled. i_start and kernel writes issued mid-operation must have no effect.
- Reset asserted mid-ACCUM after 7 pixels → the next cycle shows IDLE, all outputs 0, kernel reads back as zero. A new run with unwritten kernel returns 0.
- Two consecutive operations with a new kernel written between them → each result corresponds to its own kernel; no accumulator carry-over.
